// File: rtl/dcache_pkg.sv
// Shared types for the Dcache memory bridge: bus size codes, FSM encodings, store-buffer entry.
// Pure declarations; no latency or backpressure of its own.
package dcache_pkg;

  localparam int OFFSET_W_DEF = 2;
  localparam int LINE_WORDS   = 1 << OFFSET_W_DEF;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_DATA = 2'd2,
    R_DONE = 2'd3
  } r_state_t;

  typedef struct packed {
    logic [31:0] addr;
    mem_size_t   size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } wb_entry_t;

  // Line-aligned byte address for a line of 2**offset_w 32-bit words.
  function automatic logic [31:0] line_base(input logic [31:0] addr, input int offset_w);
    return addr & ~((32'd1 << (offset_w + 2)) - 32'd1);
  endfunction

endpackage

// File: rtl/dcache_wb_fifo.sv
// Generic synchronous FIFO with the head entry visible combinationally; push and pop in the same cycle leave count unchanged.
// Zero-latency head; push ignored when full, pop ignored when empty (caller gates with full/empty).
module dcache_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign head_dat = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (!push_ok && pop_ok) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/dcache_mem_bridge.sv
// Bridges the Dcache request port to the shared memory bus: buffered write-through stores, line or single-word reads.
// Read latency = bus latency + 1 cycle; stores are held off (addrOK=0) when the buffer is full, reads until it has drained.
module dcache_mem_bridge
  import dcache_pkg::*;
#(
  parameter int WB_DEPTH = 4,
  parameter int OFFSET_W = OFFSET_W_DEF
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          dcache_mem_req,
  input  logic                          dcache_mem_wr,
  input  logic [1:0]                    dcache_mem_size,
  input  logic [3:0]                    dcache_mem_wstrb,
  input  logic [31:0]                   dcache_mem_addr,
  input  logic [31:0]                   dcache_mem_wdata,
  input  logic                          dcache_mem_uc,
  output logic                          mem_dcache_addrOK,
  output logic                          mem_dcache_dataOK,
  output logic [32*(1<<OFFSET_W)-1:0]   mem_dcache_rdata,
  output logic                          mem_dcache_bvalid,
  output logic                          bus_req,
  output logic                          bus_wr,
  output logic [31:0]                   bus_addr,
  output logic [1:0]                    bus_size,
  output logic [3:0]                    bus_wstrb,
  output logic [31:0]                   bus_wdata,
  output logic [7:0]                    bus_len,
  input  logic                          bus_addr_ok,
  input  logic                          bus_rvalid,
  input  logic [31:0]                   bus_rdata,
  input  logic                          bus_rlast,
  input  logic                          bus_bvalid
);

  localparam int                NWORDS   = 1 << OFFSET_W;
  localparam int                CW       = $clog2(WB_DEPTH) + 1;
  localparam logic [OFFSET_W:0] NWORDS_C = (OFFSET_W+1)'(NWORDS);

  wb_entry_t             wb_push_dat;
  wb_entry_t             wb_head;
  logic                  wb_pop;
  logic                  wb_full;
  logic                  wb_empty;
  logic [CW-1:0]         wb_count;

  w_state_t              w_state, w_next;
  r_state_t              r_state, r_next;

  logic                  wr_accept;
  logic                  rd_accept;
  logic [31:0]           rd_addr;
  mem_size_t             rd_size;
  logic                  rd_uc;
  logic [OFFSET_W:0]     beat;
  logic [32*NWORDS-1:0]  rd_line;

  // Stores are accepted whenever there is room; reads only once every store has reached the bus.
  assign wr_accept = dcache_mem_req & dcache_mem_wr & ~wb_full;
  assign rd_accept = dcache_mem_req & ~dcache_mem_wr & (wb_count == '0)
                   & (w_state == W_IDLE) & (r_state == R_IDLE);

  assign mem_dcache_addrOK = wr_accept | rd_accept;
  assign mem_dcache_dataOK = (r_state == R_DONE);
  assign mem_dcache_rdata  = rd_line;
  assign mem_dcache_bvalid = (w_state == W_RESP) & bus_bvalid;

  assign wb_push_dat = '{addr:  dcache_mem_addr,
                         size:  mem_size_t'(dcache_mem_size),
                         wstrb: dcache_mem_wstrb,
                         wdata: dcache_mem_wdata};
  assign wb_pop      = (w_state == W_RESP) & bus_bvalid;

  dcache_wb_fifo #(
    .WIDTH ($bits(wb_entry_t)),
    .DEPTH (WB_DEPTH)
  ) u_wb_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (wr_accept),
    .push_dat (wb_push_dat),
    .pop      (wb_pop),
    .head_dat (wb_head),
    .full     (wb_full),
    .empty    (wb_empty),
    .count    (wb_count)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // Drain starts only while the read side is idle, so one bus transaction is outstanding at most.
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (!wb_empty && r_state == R_IDLE) w_next = W_REQ;
      W_REQ:   if (bus_addr_ok) w_next = W_RESP;
      W_RESP:  if (bus_bvalid)  w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (rd_accept) r_next = R_REQ;
      R_REQ:   if (bus_addr_ok) r_next = R_DATA;
      R_DATA:  if (bus_rvalid && bus_rlast) r_next = R_DONE;
      R_DONE:  r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_addr <= '0;
      rd_size <= MEM_WORD;
      rd_uc   <= 1'b0;
      beat    <= '0;
      rd_line <= '0;
    end else begin
      if (rd_accept) begin
        rd_addr <= dcache_mem_addr;
        rd_size <= mem_size_t'(dcache_mem_size);
        rd_uc   <= dcache_mem_uc;
      end
      if (r_state == R_REQ && bus_addr_ok) begin
        beat <= '0;
      end else if (r_state == R_DATA && bus_rvalid) begin
        beat <= beat + 1'b1;
      end
      // Beats past the end of the line are dropped rather than wrapping onto word 0.
      if (r_state == R_DATA && bus_rvalid && beat < NWORDS_C) begin
        if (rd_uc) rd_line <= {NWORDS{bus_rdata}};
        else       rd_line[32*int'(beat[OFFSET_W-1:0]) +: 32] <= bus_rdata;
      end
    end
  end

  always_comb begin
    bus_req   = 1'b0;
    bus_wr    = 1'b0;
    bus_addr  = '0;
    bus_size  = MEM_WORD;
    bus_wstrb = '0;
    bus_wdata = '0;
    bus_len   = '0;
    if (w_state == W_REQ) begin
      bus_req   = 1'b1;
      bus_wr    = 1'b1;
      bus_addr  = wb_head.addr;
      bus_size  = wb_head.size;
      bus_wstrb = wb_head.wstrb;
      bus_wdata = wb_head.wdata;
    end else if (r_state == R_REQ) begin
      bus_req  = 1'b1;
      bus_addr = rd_uc ? rd_addr : line_base(rd_addr, OFFSET_W);
      bus_size = rd_uc ? rd_size : MEM_WORD;
      bus_len  = rd_uc ? 8'd0 : 8'(NWORDS - 1);
    end
  end

endmodule

// File: tb/tb_dcache_mem_bridge.sv
// Randomised bench for dcache_mem_bridge: a reactive bus responder plus a transaction-level model of the
// store queue, read line and handshake expectations, checked every cycle on the falling edge.
module tb_dcache_mem_bridge;
  import dcache_pkg::*;

  localparam int WB_DEPTH = 4;
  localparam int LW       = LINE_WORDS;

  logic              clk;
  logic              rstn;
  logic              dcache_mem_req;
  logic              dcache_mem_wr;
  logic [1:0]        dcache_mem_size;
  logic [3:0]        dcache_mem_wstrb;
  logic [31:0]       dcache_mem_addr;
  logic [31:0]       dcache_mem_wdata;
  logic              dcache_mem_uc;
  logic              mem_dcache_addrOK;
  logic              mem_dcache_dataOK;
  logic [32*LW-1:0]  mem_dcache_rdata;
  logic              mem_dcache_bvalid;
  logic              bus_req;
  logic              bus_wr;
  logic [31:0]       bus_addr;
  logic [1:0]        bus_size;
  logic [3:0]        bus_wstrb;
  logic [31:0]       bus_wdata;
  logic [7:0]        bus_len;
  logic              bus_addr_ok;
  logic              bus_rvalid;
  logic [31:0]       bus_rdata;
  logic              bus_rlast;
  logic              bus_bvalid;

  dcache_mem_bridge #(.WB_DEPTH(WB_DEPTH), .OFFSET_W(OFFSET_W_DEF)) dut (
    .clk(clk), .rstn(rstn),
    .dcache_mem_req(dcache_mem_req), .dcache_mem_wr(dcache_mem_wr),
    .dcache_mem_size(dcache_mem_size), .dcache_mem_wstrb(dcache_mem_wstrb),
    .dcache_mem_addr(dcache_mem_addr), .dcache_mem_wdata(dcache_mem_wdata),
    .dcache_mem_uc(dcache_mem_uc),
    .mem_dcache_addrOK(mem_dcache_addrOK), .mem_dcache_dataOK(mem_dcache_dataOK),
    .mem_dcache_rdata(mem_dcache_rdata), .mem_dcache_bvalid(mem_dcache_bvalid),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_size(bus_size),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_len(bus_len),
    .bus_addr_ok(bus_addr_ok), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .bus_rlast(bus_rlast), .bus_bvalid(bus_bvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } st_t;

  // Transaction-level model state
  st_t          wq[$];
  int           pend = 0;
  int           n_acc = 0;
  int           n_bv = 0;
  bit           rd_busy = 0;
  bit           dok_pending = 0;
  bit           rd_uc_m = 0;
  int           rd_beat = 0;
  int           rd_nbeats = 0;
  logic [31:0]  rd_exp_addr = '0;
  logic [1:0]   rd_exp_size = '0;
  logic [7:0]   rd_exp_len = '0;
  logic [127:0] exp_line = '0;

  always @(negedge clk) begin
    if (!rstn) begin
      wq.delete();
      pend = 0; n_acc = 0; n_bv = 0;
      rd_busy = 0; dok_pending = 0; rd_beat = 0; exp_line = '0;
    end else begin
      if (dcache_mem_req) begin
        if (dcache_mem_wr) chk_eq("wr_addrOK", 128'(mem_dcache_addrOK), 128'(pend != WB_DEPTH));
        else               chk_eq("rd_addrOK", 128'(mem_dcache_addrOK), 128'(pend == 0 && !rd_busy));
      end else begin
        chk_eq("idle_addrOK", 128'(mem_dcache_addrOK), 128'(0));
      end
      chk_eq("dataOK", 128'(mem_dcache_dataOK), 128'(dok_pending));
      if (mem_dcache_dataOK && dok_pending) chk_eq("rdata", 128'(mem_dcache_rdata), exp_line);
      chk_eq("bvalid", 128'(mem_dcache_bvalid), 128'(bus_bvalid));

      if (bus_req && bus_addr_ok) begin
        if (bus_wr) begin
          chk_eq("wr_has_entry", 128'(wq.size() > 0), 128'(1));
          if (wq.size() > 0)
            chk_eq("wr_bus", 128'({bus_addr, bus_size, bus_wstrb, bus_wdata, bus_len}),
                   128'({wq[0].addr, wq[0].size, wq[0].wstrb, wq[0].wdata, 8'd0}));
        end else begin
          chk_eq("rd_bus", 128'({rd_busy, bus_addr, bus_size, bus_len}),
                 128'({1'b1, rd_exp_addr, rd_exp_size, rd_exp_len}));
        end
      end

      if (bus_rvalid) begin
        chk_eq("beat_in_line", 128'(rd_beat < rd_nbeats), 128'(1));
        if (rd_uc_m) begin
          for (int k = 0; k < LW; k++) exp_line[32*k +: 32] = bus_rdata;
        end else if (rd_beat < LW) begin
          exp_line[32*rd_beat +: 32] = bus_rdata;
        end
        rd_beat++;
      end

      if (dok_pending) rd_busy = 0;
      dok_pending = bus_rvalid && bus_rlast;
      if (mem_dcache_bvalid && wq.size() > 0) begin
        void'(wq.pop_front());
        pend--;
        n_bv++;
      end
      if (dcache_mem_req && mem_dcache_addrOK) begin
        if (dcache_mem_wr) begin
          wq.push_back('{dcache_mem_addr, dcache_mem_size, dcache_mem_wstrb, dcache_mem_wdata});
          pend++;
          n_acc++;
        end else begin
          rd_busy     = 1;
          rd_uc_m     = dcache_mem_uc;
          rd_beat     = 0;
          rd_exp_addr = dcache_mem_uc ? dcache_mem_addr : (dcache_mem_addr & ~32'(LW*4 - 1));
          rd_exp_size = dcache_mem_uc ? dcache_mem_size : 2'd2;
          rd_exp_len  = dcache_mem_uc ? 8'd0 : 8'(LW - 1);
          rd_nbeats   = int'(rd_exp_len) + 1;
        end
      end
    end
  end

  // Reactive bus slave; abandons whatever it is doing when reset is seen on a clock edge.
  int min_lat = 0, max_lat = 2, min_gap = 0, max_gap = 2;

  task automatic tick(inout bit ab);
    @(posedge clk);
    if (!rstn) ab = 1;
    #1;
    bus_addr_ok = 0; bus_rvalid = 0; bus_rlast = 0; bus_bvalid = 0;
  endtask

  initial begin : bus_model
    bus_addr_ok = 0; bus_rvalid = 0; bus_rlast = 0; bus_bvalid = 0; bus_rdata = '0;
    forever begin
      bit ab;
      bit is_wr;
      int nb;
      int d;
      ab = 0;
      tick(ab);
      if (!ab && rstn && bus_req) begin
        d = $urandom_range(max_lat, min_lat);
        for (int i = 0; i < d && !ab; i++) tick(ab);
        is_wr = bus_wr;
        nb    = int'(bus_len) + 1;
        if (!ab) begin
          bus_addr_ok = 1;
          tick(ab);
        end
        if (is_wr) begin
          d = $urandom_range(max_gap, min_gap);
          for (int i = 0; i < d && !ab; i++) tick(ab);
          if (!ab) begin
            bus_bvalid = 1;
            tick(ab);
          end
        end else begin
          for (int b = 0; b < nb && !ab; b++) begin
            d = $urandom_range(max_gap, min_gap);
            for (int i = 0; i < d && !ab; i++) tick(ab);
            if (!ab) begin
              bus_rvalid = 1;
              bus_rdata  = $urandom;
              bus_rlast  = (b == nb - 1);
              tick(ab);
            end
          end
        end
      end
    end
  end

  // Dcache-side driver: holds the request until it is accepted (bounded).
  task automatic issue(input bit wr, input logic [1:0] sz, input logic [3:0] st,
                       input logic [31:0] a, input logic [31:0] d, input bit uc);
    bit got;
    got = 0;
    dcache_mem_req = 1; dcache_mem_wr = wr; dcache_mem_size = sz;
    dcache_mem_wstrb = st; dcache_mem_addr = a; dcache_mem_wdata = d; dcache_mem_uc = uc;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (mem_dcache_addrOK) begin
        got = 1;
        break;
      end
    end
    chk_eq("addrOK_wait", 128'(got), 128'(1));
    @(posedge clk); #1;
    dcache_mem_req = 0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int t = 0; t < 2000; t++) begin
      @(posedge clk);
      if (pend == 0 && !rd_busy && !dok_pending) begin
        idle = 1;
        break;
      end
    end
    #1;
    chk_eq("drain_wait", 128'(idle), 128'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_eq({tag, "_addrOK"}, 128'(mem_dcache_addrOK), 128'(0));
    chk_eq({tag, "_dataOK"}, 128'(mem_dcache_dataOK), 128'(0));
    chk_eq({tag, "_rdata"},  128'(mem_dcache_rdata),  128'(0));
    chk_eq({tag, "_bvalid"}, 128'(mem_dcache_bvalid), 128'(0));
    chk_eq({tag, "_bus"}, 128'({bus_req, bus_wr, bus_addr, bus_wstrb, bus_wdata, bus_len}), 128'(0));
    chk_eq({tag, "_bus_size"}, 128'(bus_size), 128'(2));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin : stim
    bit got;
    rstn = 0;
    dcache_mem_req = 0; dcache_mem_wr = 0; dcache_mem_size = '0; dcache_mem_wstrb = '0;
    dcache_mem_addr = '0; dcache_mem_wdata = '0; dcache_mem_uc = 0;
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;

    // Cached line read
    issue(0, 2'd2, 4'h0, 32'h0000_1004, 32'h0, 0);
    wait_idle();

    // Back-to-back stores against a slow bus, so the buffer fills
    min_lat = 4; max_lat = 6;
    for (int i = 0; i < 5; i++) issue(1, 2'd2, 4'hF, 32'h0000_3000 + 32'(4*i), $urandom, 0);
    wait_idle();
    min_lat = 0; max_lat = 2;

    // Store then read of the same address
    issue(1, 2'd2, 4'hF, 32'h0000_2000, 32'hCAFE_F00D, 0);
    issue(0, 2'd2, 4'h0, 32'h0000_2000, 32'h0, 0);
    wait_idle();

    // Uncached single-word read
    issue(0, 2'd2, 4'h0, 32'hBF00_0008, 32'h0, 1);
    wait_idle();

    // Continuous pushing while the buffer is full and draining
    min_lat = 0; max_lat = 1; min_gap = 0; max_gap = 1;
    for (int i = 0; i < 12; i++) issue(1, 2'($urandom_range(2, 0)), 4'($urandom), $urandom, $urandom, 0);
    wait_idle();

    // Reset in the middle of a read's data phase with two stores queued
    min_lat = 0; max_lat = 1; min_gap = 2; max_gap = 3;
    issue(0, 2'd2, 4'h0, 32'h0000_4000, 32'h0, 0);
    issue(1, 2'd2, 4'hF, 32'h0000_5000, $urandom, 0);
    issue(1, 2'd2, 4'hF, 32'h0000_5004, $urandom, 0);
    got = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus_rvalid && !bus_rlast) begin
        got = 1;
        break;
      end
    end
    chk_eq("rst_in_rdata", 128'(got), 128'(1));
    @(posedge clk); #1 rstn = 0;
    @(posedge clk); #1 rstn = 1;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    repeat (20) begin @(posedge clk); #1; end
    issue(0, 2'd2, 4'h0, 32'h0000_6000, 32'h0, 0);
    wait_idle();

    // Random mix
    for (int i = 0; i < 150; i++) begin
      min_lat = 0; max_lat = $urandom_range(4, 0);
      min_gap = 0; max_gap = $urandom_range(3, 0);
      if ($urandom_range(1, 0) == 1)
        issue(1, 2'($urandom_range(2, 0)), 4'($urandom), $urandom, $urandom, 0);
      else
        issue(0, 2'($urandom_range(2, 0)), 4'h0, $urandom, 32'h0, bit'($urandom_range(1, 0)));
      repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
    end
    wait_idle();

    chk_eq("bvalid_total", 128'(n_bv), 128'(n_acc));
    chk_eq("queue_empty", 128'(wq.size()), 128'(0));
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
